coraz7_uart_tx: RTL

- Board-side UART transmitter for the Cora Z7 FPGA wrapper.
- Accepts bytes from the LETC core side over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each byte as 8N1 onto the board UART TX pin.
- It is the outbound end of the core-to-host debug console. The matching receive path is a separate block.

---
 rtl/coraz7_uart_tx.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/coraz7_uart_tx.sv
// Outbound debug-console UART for the Cora Z7 wrapper: a small byte FIFO
// on a valid/ready handshake, drained by an 8N1 serialiser onto uart_txd.
module coraz7_uart_tx #(
  parameter int CLK_FREQ_HZ = 125000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [7:0]                  tx_data,
  output logic                        uart_txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CLKS_PER_BIT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;

  state_t        state_reg, state_next;
  logic [BW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          txd_reg, txd_next;
  logic          bit_done;

  assign tx_ready   = (count_reg != FIFO_FULL);
  assign push       = tx_valid && tx_ready;
  assign bit_done   = (baud_cnt_reg == BAUD_LAST);
  assign uart_txd   = txd_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != '0);
  assign fifo_count = count_reg;

  // Storage has no reset so it maps onto RAM; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // The head byte is read synchronously straight into the shifter on a pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_reg <= mem[rd_ptr_reg];
    end else begin
      shift_reg <= shift_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      txd_reg      <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      txd_reg      <= txd_next;
    end
  end

  // txd_next is the level of the coming cycle, so the line never lags a state change.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    txd_next      = txd_reg;
    pop           = 1'b0;

    case (state_reg)
      IDLE: begin
        txd_next      = 1'b1;
        baud_cnt_next = '0;
        if (count_reg != '0) begin
          pop        = 1'b1;
          txd_next   = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          txd_next      = shift_reg[0];
          state_next    = DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            txd_next   = 1'b1;
            state_next = STOP;
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            txd_next     = shift_reg[1];
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_next = '0;
          if (count_reg != '0) begin
            pop        = 1'b1;
            txd_next   = 1'b0;
            state_next = START;
          end else begin
            txd_next   = 1'b1;
            state_next = IDLE;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end
      default: begin
        txd_next   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

endmodule
